// File: rtl/mid_frame_ctrl.sv
// mid_frame_ctrl: frame sequencer for the median-filter path.
// It detects frame starts on y_vs and pulses the pipeline clear.
// It latches filter/bypass mode only at frame boundaries.
// It checks input geometry against COL x ROW.
// It counts drained output lines (mid_de) to flag frame completion.
module mid_frame_ctrl #(
  parameter int COL     = 640,
  parameter int ROW     = 480,
  parameter int CLR_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        y_vs,
  input  logic        y_de,
  input  logic        mid_de,
  input  logic        cfg_filt_en,
  output logic        pipe_rst_n,
  output logic        sel_filt,
  output logic        frame_start,
  output logic        frame_done,
  output logic        geo_err,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_cnt,
  output logic [1:0]  state
);

  localparam int PW = $clog2(COL + 1);
  localparam int LW = $clog2(ROW + 1);
  localparam int CW = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;

  localparam logic [PW-1:0] PIX_SAT  = {PW{1'b1}};
  localparam logic [PW-1:0] COL_V    = PW'(COL);
  localparam logic [LW-1:0] ROW_V    = LW'(ROW);
  localparam logic [LW-1:0] OUT_SAT  = {LW{1'b1}};
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t        st, st_nx;
  logic          vs_r, de_r, mde_r;
  logic          vs_rise, de_fall, mde_fall;
  logic [CW-1:0] clr_cnt, clr_nx;
  logic [PW-1:0] pix_cnt, pix_nx;
  logic [LW-1:0] line_cnt, line_nx;
  logic [LW-1:0] out_cnt, out_nx;
  logic          sel_nx, start_nx, done_nx, err_nx, accept;
  logic [7:0]    errc_nx;
  logic [15:0]   fcnt_nx;

  assign vs_rise  = y_vs & ~vs_r;
  assign de_fall  = de_r & ~y_de;
  assign mde_fall = mde_r & ~mid_de;
  assign state    = st;

  // Next-state and next-output decode for the frame sequencer
  always_comb begin
    st_nx    = st;
    clr_nx   = clr_cnt;
    pix_nx   = pix_cnt;
    line_nx  = line_cnt;
    out_nx   = out_cnt;
    sel_nx   = sel_filt;
    start_nx = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    fcnt_nx  = frame_cnt;
    accept   = 1'b0;

    // Output lines drain in every state except while the pipe is being cleared
    if (st != S_CLEAR && mde_fall && out_cnt != OUT_SAT)
      out_nx = out_cnt + LW'(1);

    case (st)
      S_IDLE: begin
        accept = vs_rise;
      end
      S_CLEAR: begin
        // Pixels arriving while the pipe is held in clear are lost
        if (y_de) err_nx = 1'b1;
        if (vs_rise)
          clr_nx = CLR_LAST;
        else if (clr_cnt == '0)
          st_nx = S_ACTIVE;
        else
          clr_nx = clr_cnt - CW'(1);
      end
      S_ACTIVE: begin
        if (y_de && pix_cnt != PIX_SAT) pix_nx = pix_cnt + PW'(1);
        if (de_fall) begin
          if (pix_cnt != COL_V) err_nx = 1'b1;
          line_nx = line_cnt + LW'(1);
          pix_nx  = '0;
          if (line_nx == ROW_V) st_nx = S_DRAIN;
        end
        // A new frame always wins; it is short only if lines are still missing
        if (vs_rise) begin
          if (line_nx < ROW_V) err_nx = 1'b1;
          accept = 1'b1;
        end
      end
      S_DRAIN: begin
        if (de_fall) err_nx = 1'b1;
        if (out_nx >= ROW_V) begin
          done_nx = 1'b1;
          fcnt_nx = frame_cnt + 16'd1;
          st_nx   = S_IDLE;
        end
        if (vs_rise) begin
          if (!done_nx) err_nx = 1'b1;
          accept = 1'b1;
        end
      end
      default: st_nx = S_IDLE;
    endcase

    if (accept) begin
      st_nx    = S_CLEAR;
      clr_nx   = CLR_LAST;
      sel_nx   = cfg_filt_en;
      start_nx = 1'b1;
      pix_nx   = '0;
      line_nx  = '0;
      out_nx   = '0;
    end

    errc_nx = (err_nx && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
  end

  // State, counters, edge history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      vs_r        <= 1'b0;
      de_r        <= 1'b0;
      mde_r       <= 1'b0;
      clr_cnt     <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      out_cnt     <= '0;
      pipe_rst_n  <= 1'b0;
      sel_filt    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      geo_err     <= 1'b0;
      err_cnt     <= 8'd0;
      frame_cnt   <= 16'd0;
    end else begin
      st          <= st_nx;
      vs_r        <= y_vs;
      de_r        <= y_de;
      mde_r       <= mid_de;
      clr_cnt     <= clr_nx;
      pix_cnt     <= pix_nx;
      line_cnt    <= line_nx;
      out_cnt     <= out_nx;
      pipe_rst_n  <= (st_nx != S_CLEAR);
      sel_filt    <= sel_nx;
      frame_start <= start_nx;
      frame_done  <= done_nx;
      geo_err     <= err_nx;
      err_cnt     <= errc_nx;
      frame_cnt   <= fcnt_nx;
    end
  end

endmodule

// File: tb/tb_mid_frame_ctrl.sv
// tb_mid_frame_ctrl: table-driven, hand-sequenced and randomized checks of mid_frame_ctrl
// against a cycle-stamped behavioural model.
module tb_mid_frame_ctrl;

  localparam int COL     = 8;
  localparam int ROW     = 4;
  localparam int CLR_LEN = 4;
  localparam int PIX_SAT = (1 << $clog2(COL + 1)) - 1;
  localparam int OUT_SAT = (1 << $clog2(ROW + 1)) - 1;

  logic        clk = 1'b0;
  logic        rst_n, y_vs, y_de, mid_de, cfg_filt_en;
  logic        pipe_rst_n, sel_filt, frame_start, frame_done, geo_err;
  logic [7:0]  err_cnt;
  logic [15:0] frame_cnt;
  logic [1:0]  state;

  mid_frame_ctrl #(.COL(COL), .ROW(ROW), .CLR_LEN(CLR_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .y_vs(y_vs), .y_de(y_de), .mid_de(mid_de),
    .cfg_filt_en(cfg_filt_en), .pipe_rst_n(pipe_rst_n), .sel_filt(sel_filt),
    .frame_start(frame_start), .frame_done(frame_done), .geo_err(geo_err),
    .err_cnt(err_cnt), .frame_cnt(frame_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_done = 0;
  logic [2:0] dl = 3'b000;
  bit cfg_rand = 0;
  bit cfg_tog = 0;

  // Behavioural model: phase 0 idle, 1 clear, 2 active, 3 drain
  int t, m_ph, m_clr_end, m_pix, m_lines, m_outl, m_errs, m_frames;
  bit m_sel, m_start, m_done, m_err, m_pipe, m_vs, m_de, m_mde;

  task automatic model_reset();
    t = 0; m_ph = 0; m_clr_end = 0; m_pix = 0; m_lines = 0; m_outl = 0;
    m_errs = 0; m_frames = 0; m_sel = 0; m_start = 0; m_done = 0; m_err = 0;
    m_pipe = 0; m_vs = 0; m_de = 0; m_mde = 0;
  endtask

  task automatic model_step();
    bit vsr, def, mdf, nf;
    t++;
    vsr = y_vs && !m_vs;
    def = m_de && !y_de;
    mdf = m_mde && !mid_de;
    m_start = 0; m_done = 0; m_err = 0; nf = 0;
    if (m_ph != 1 && mdf && m_outl < OUT_SAT) m_outl++;
    case (m_ph)
      0: nf = vsr;
      1: begin
        if (y_de) m_err = 1;
        if (vsr) m_clr_end = t + CLR_LEN - 1;
        else if (t > m_clr_end) m_ph = 2;
      end
      2: begin
        if (y_de && m_pix < PIX_SAT) m_pix++;
        if (def) begin
          if (m_pix != COL) m_err = 1;
          m_lines++;
          m_pix = 0;
          if (m_lines == ROW) m_ph = 3;
        end
        if (vsr) begin
          if (m_lines < ROW) m_err = 1;
          nf = 1;
        end
      end
      default: begin
        if (def) m_err = 1;
        if (m_outl >= ROW) begin
          m_done = 1;
          m_frames = (m_frames + 1) % 65536;
          m_ph = 0;
        end
        if (vsr) begin
          if (!m_done) m_err = 1;
          nf = 1;
        end
      end
    endcase
    if (nf) begin
      m_ph = 1; m_clr_end = t + CLR_LEN - 1; m_sel = cfg_filt_en; m_start = 1;
      m_pix = 0; m_lines = 0; m_outl = 0;
    end
    if (m_err && m_errs < 255) m_errs++;
    m_pipe = (m_ph != 1);
    m_vs = y_vs; m_de = y_de; m_mde = mid_de;
  endtask

  function automatic logic [31:0] dut_bus();
    return {1'b0, pipe_rst_n, sel_filt, frame_start, frame_done, geo_err,
            err_cnt, frame_cnt, state};
  endfunction

  function automatic logic [31:0] exp_bus();
    logic [31:0] e, w;
    logic [31:0] f, p;
    w = m_errs; f = m_frames; p = m_ph;
    e = {1'b0, m_pipe, m_sel, m_start, m_done, m_err, w[7:0], f[15:0], p[1:0]};
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, got, exp, t);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    if (frame_done) n_done++;
    check(name, dut_bus(), exp_bus());
  endtask

  task automatic cyc(input logic vs, input logic de);
    y_vs = vs;
    y_de = de;
    mid_de = dl[2];
    if (cfg_rand) cfg_filt_en = 1'($urandom_range(0, 1));
    else if (cfg_tog) cfg_filt_en = ~cfg_filt_en;
    tick("model cycle");
    dl = {dl[1:0], de};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic line(input int npix, input int gap, output logic ge);
    for (int i = 0; i < npix; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    ge = geo_err;
    for (int i = 1; i < gap; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic frame_start_seq();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    idle(3);
  endtask

  typedef struct packed {
    logic       vs, de, cfg;
    logic       pipe, start;
    logic [1:0] st;
    logic       sel;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic ge;
    int nl, np, r;

    // T1 vectors: entry i drives cycle i, expectations are for cycle i+1
    for (int i = 0; i < 10; i++) tbl[i] = '{vs:0, de:0, cfg:0, pipe:1, start:0, st:2'd0, sel:0};
    tbl[10] = '{vs:1, de:0, cfg:1, pipe:0, start:1, st:2'd1, sel:1};
    tbl[11] = '{vs:1, de:0, cfg:1, pipe:0, start:0, st:2'd1, sel:1};
    tbl[12] = '{vs:0, de:0, cfg:1, pipe:0, start:0, st:2'd1, sel:1};
    tbl[13] = '{vs:0, de:0, cfg:1, pipe:0, start:0, st:2'd1, sel:1};
    tbl[14] = '{vs:0, de:0, cfg:1, pipe:1, start:0, st:2'd2, sel:1};

    rst_n = 1'b1; y_vs = 1'b0; y_de = 1'b0; mid_de = 1'b0; cfg_filt_en = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check("reset values", dut_bus(), 32'h0);
    repeat (3) tick("held in reset");
    rst_n = 1'b1;

    // T1: frame start timing and clear pulse length
    for (int i = 0; i < 15; i++) begin
      cfg_filt_en = tbl[i].cfg;
      cyc(tbl[i].vs, tbl[i].de);
      check($sformatf("T1 cycle %0d", i + 1),
            {27'd0, pipe_rst_n, frame_start, state, sel_filt},
            {27'd0, tbl[i].pipe, tbl[i].start, tbl[i].st, tbl[i].sel});
    end

    // T2: full well-formed frame
    n_done = 0;
    repeat (ROW) line(COL, 3, ge);
    idle(8);
    check("T2 frame_done pulses", n_done, 1);
    check("T2 frame_cnt", frame_cnt, 1);
    check("T2 err_cnt", err_cnt, 0);

    // T3: one line one pixel short
    n_done = 0;
    frame_start_seq();
    line(COL, 3, ge);
    check("T3 good line geo_err", ge, 0);
    line(COL - 1, 3, ge);
    check("T3 short line geo_err", ge, 1);
    line(COL, 3, ge);
    line(COL, 3, ge);
    idle(8);
    check("T3 err_cnt", err_cnt, 1);
    check("T3 frame_done pulses", n_done, 1);
    check("T3 frame_cnt", frame_cnt, 2);

    // T4: short frame cut by a new vsync after two lines
    n_done = 0;
    cfg_filt_en = 1'b0;
    frame_start_seq();
    check("T4 sel latched 0", sel_filt, 0);
    line(COL, 3, ge);
    line(COL, 3, ge);
    cfg_filt_en = 1'b1;
    cyc(1'b1, 1'b0);
    check("T4 geo_err", geo_err, 1);
    check("T4 frame_start", frame_start, 1);
    check("T4 state CLEAR", state, 1);
    check("T4 no frame_done", n_done, 0);
    check("T4 sel latched 1", sel_filt, 1);
    cyc(1'b0, 1'b0);
    idle(3);

    // T5: cfg toggling mid-frame must not move sel_filt
    cfg_tog = 1;
    for (int l = 0; l < ROW; l++) begin
      line(COL, 3, ge);
      check($sformatf("T5 sel hold line %0d", l), sel_filt, 1);
    end
    idle(8);
    cfg_tog = 0;
    check("T5 frame completes", n_done, 1);
    cfg_filt_en = 1'b0;
    cyc(1'b1, 1'b0);
    check("T5 sel at next start", sel_filt, 0);
    check("T5 frame_start", frame_start, 1);

    // T6: saturate err_cnt by streaming pixels through a held clear
    for (int i = 0; i < 300; i++) cyc(1'(i % 2), 1'b1);
    check("T6 err_cnt saturated", err_cnt, 255);
    idle(6);
    check("T6 state ACTIVE", state, 2);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    rst_n = 1'b0; y_vs = 1'b0; y_de = 1'b0; mid_de = 1'b0; dl = 3'b000;
    #1 check("T6 async reset mid-frame", dut_bus(), 32'h0);
    model_reset();
    repeat (2) tick("T6 held in reset");
    rst_n = 1'b1;
    n_done = 0;
    idle(2);
    frame_start_seq();
    repeat (ROW) line(COL, 2, ge);
    idle(8);
    check("T6 clean frame done", n_done, 1);
    check("T6 clean frame_cnt", frame_cnt, 1);
    check("T6 clean err_cnt", err_cnt, 0);

    // Randomized frames: geometry faults, early vsyncs and cfg noise
    cfg_rand = 1;
    for (int f = 0; f < 40; f++) begin
      repeat (1 + $urandom_range(0, 1)) cyc(1'b1, 1'b0);
      idle(1 + $urandom_range(0, 5));
      r = $urandom_range(0, 7);
      nl = (r == 0) ? $urandom_range(1, ROW - 1) : (r == 1) ? ROW + 1 : ROW;
      for (int l = 0; l < nl; l++) begin
        r = $urandom_range(0, 9);
        np = (r == 0) ? COL - 1 : (r == 1) ? COL + 1 : (r == 2) ? COL + 9 : COL;
        line(np, 1 + $urandom_range(0, 3), ge);
      end
      if ($urandom_range(0, 3) != 0) idle(4 + $urandom_range(0, 9));
    end
    cfg_rand = 0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
